// File: rtl/instruction_fetch.sv
// Fetch stage: holds the architectural PC and issues one instruction-memory read
// per fetch phase over a req/ack handshake, presenting the word and its address to decode.
module instruction_fetch #(
  parameter int unsigned      XLEN         = 32,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
  parameter logic [31:0]      NOP_INST     = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            phase_fetch,
  input  logic            phase_writeback,
  input  logic            jump_state,
  input  logic [XLEN-1:0] next_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic            stall_fetch
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pend;
  logic            r_pend_valid;
  logic            r_imem_req;
  logic [XLEN-1:0] r_imem_addr;
  logic [31:0]     r_inst;
  logic [XLEN-1:0] r_curr_pc_fd;

  logic [XLEN-1:0] w_jump_target;
  logic [XLEN-1:0] w_target;

  // Jump targets are forced word-aligned; misaligned low bits are silently dropped.
  assign w_jump_target = next_pc & ~XLEN'(3);
  assign w_target      = jump_state ? w_jump_target : r_pc + XLEN'(4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_VECTOR;
      r_pend       <= RESET_VECTOR;
      r_pend_valid <= 1'b0;
      r_imem_req   <= 1'b0;
      r_imem_addr  <= RESET_VECTOR;
      r_inst       <= NOP_INST;
      r_curr_pc_fd <= RESET_VECTOR;
    end else begin
      case (r_state)
        IDLE: begin
          if (phase_fetch) begin
            r_imem_req  <= 1'b1;
            r_imem_addr <= r_pc;
            r_state     <= WAIT;
          end
          if (phase_writeback) begin
            r_pc <= w_target;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            r_inst       <= imem_rdata;
            r_curr_pc_fd <= r_imem_addr;
            r_imem_req   <= 1'b0;
            r_state      <= IDLE;
            r_pend_valid <= 1'b0;
            // A writeback on the ack edge itself wins over any older pending target.
            if (phase_writeback) begin
              r_pc <= w_target;
            end else if (r_pend_valid) begin
              r_pc <= r_pend;
            end
          end else if (phase_writeback) begin
            r_pend       <= w_target;
            r_pend_valid <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign inst        = r_inst;
  assign curr_pc_fd  = r_curr_pc_fd;
  assign stall_fetch = (r_state == WAIT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a table of single-cycle vectors followed by
// hand-written sequences for delayed acknowledge and asynchronous reset mid-request.
module tb_instruction_fetch;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            phase_fetch;
  logic            phase_writeback;
  logic            jump_state;
  logic [XLEN-1:0] next_pc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic [31:0]     inst;
  logic [XLEN-1:0] curr_pc_fd;
  logic            stall_fetch;

  int errors = 0;
  int checks = 0;

  instruction_fetch #(
    .XLEN         (XLEN),
    .RESET_VECTOR (32'h0000_0000),
    .NOP_INST     (NOP)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .phase_fetch     (phase_fetch),
    .phase_writeback (phase_writeback),
    .jump_state      (jump_state),
    .next_pc         (next_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .inst            (inst),
    .curr_pc_fd      (curr_pc_fd),
    .stall_fetch     (stall_fetch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pf;
    logic        pw;
    logic        js;
    logic [31:0] npc;
    logic        ack;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] einst;
    logic [31:0] ecurr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic pf, logic pw, logic js, logic [31:0] npc,
                              logic ack, logic [31:0] rdata, logic ereq,
                              logic [31:0] eaddr, logic [31:0] einst, logic [31:0] ecurr);
    vec_t v;
    v.pf = pf; v.pw = pw; v.js = js; v.npc = npc; v.ack = ack; v.rdata = rdata;
    v.ereq = ereq; v.eaddr = eaddr; v.einst = einst; v.ecurr = ecurr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    phase_fetch = 1'b0; phase_writeback = 1'b0; jump_state = 1'b0;
    next_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ereq, input logic [31:0] eaddr,
                         input logic [31:0] einst, input logic [31:0] ecurr);
    chk({tag, ".imem_req"},    {31'b0, imem_req},    {31'b0, ereq});
    chk({tag, ".stall_fetch"}, {31'b0, stall_fetch}, {31'b0, ereq});
    chk({tag, ".imem_addr"},   imem_addr,  eaddr);
    chk({tag, ".inst"},        inst,       einst);
    chk({tag, ".curr_pc_fd"},  curr_pc_fd, ecurr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_stall;

    //            pf pw js npc           ack rdata         req addr          inst          curr
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        NOP,          32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h00500093, 0, 32'h0,        32'h00500093, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h107,      0, 32'h0,        0, 32'h0,        32'h00500093, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h104,      32'h00500093, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hAAAA0001, 0, 32'h104,      32'hAAAA0001, 32'h104));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h104,      32'hAAAA0001, 32'h104));
    vecs.push_back(mk(1, 1, 1, 32'h300,      0, 32'h0,        1, 32'h108,      32'hAAAA0001, 32'h104));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h108,      32'hAAAA0001, 32'h104));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hBBBB0002, 0, 32'h108,      32'hBBBB0002, 32'h108));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h300,      32'hBBBB0002, 32'h108));
    vecs.push_back(mk(0, 1, 1, 32'h200,      0, 32'h0,        1, 32'h300,      32'hBBBB0002, 32'h108));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h300,      32'hBBBB0002, 32'h108));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hCCCC0003, 0, 32'h300,      32'hCCCC0003, 32'h300));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h200,      32'hCCCC0003, 32'h300));
    vecs.push_back(mk(0, 1, 1, 32'h400,      1, 32'hDDDD0004, 0, 32'h200,      32'hDDDD0004, 32'h200));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h400,      32'hDDDD0004, 32'h200));
    vecs.push_back(mk(0, 1, 1, 32'h500,      0, 32'h0,        1, 32'h400,      32'hDDDD0004, 32'h200));
    vecs.push_back(mk(0, 1, 1, 32'h600,      0, 32'h0,        1, 32'h400,      32'hDDDD0004, 32'h200));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'hEEEE0005, 0, 32'h400,      32'hEEEE0005, 32'h400));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h600,      32'hEEEE0005, 32'h400));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h00000001, 0, 32'h600,      32'h00000001, 32'h600));
    vecs.push_back(mk(0, 1, 1, 32'hFFFFFFFF, 0, 32'h0,        0, 32'h600,      32'h00000001, 32'h600));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'hFFFFFFFC, 32'h00000001, 32'h600));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h00000002, 0, 32'hFFFFFFFC, 32'h00000002, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 32'hFFFFFFFC, 32'h00000002, 32'hFFFFFFFC));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0,        32'h00000002, 32'hFFFFFFFC));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h00000003, 0, 32'h0,        32'h00000003, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0000DEAD, 0, 32'h0,        32'h00000003, 32'h0));

    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 32'h0, NOP, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      phase_fetch     = vecs[i].pf;
      phase_writeback = vecs[i].pw;
      jump_state      = vecs[i].js;
      next_pc         = vecs[i].npc;
      imem_ack        = vecs[i].ack;
      imem_rdata      = vecs[i].rdata;
      step();
      clear_inputs();
      chk_all($sformatf("vec%0d", i), vecs[i].ereq, vecs[i].eaddr, vecs[i].einst, vecs[i].ecurr);
    end

    // Ack delayed three cycles, with a fetch pulse arriving mid-wait.
    n_stall = 0;
    phase_fetch = 1'b1;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      if (stall_fetch) n_stall++;
      chk($sformatf("delay.addr%0d", i), imem_addr, 32'h0);
      chk($sformatf("delay.req%0d", i), {31'b0, imem_req}, 32'h1);
      if (i == 0) phase_fetch = 1'b1;
      if (i < 2) begin
        step();
        clear_inputs();
      end
    end
    imem_ack = 1'b1; imem_rdata = 32'h0040_0113;
    step();
    clear_inputs();
    if (stall_fetch) n_stall++;
    chk("delay.stall_cycles", n_stall, 32'd3);
    chk("delay.inst", inst, 32'h0040_0113);
    chk("delay.curr", curr_pc_fd, 32'h0);
    step();
    chk("delay.no_extra_req", {31'b0, imem_req}, 32'h0);
    chk("delay.no_extra_stall", {31'b0, stall_fetch}, 32'h0);

    // Asynchronous reset while a request is outstanding.
    phase_writeback = 1'b1; jump_state = 1'b1; next_pc = 32'h80;
    step();
    clear_inputs();
    phase_fetch = 1'b1;
    step();
    clear_inputs();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    clear_inputs();
    chk("rst.pre_inst", inst, 32'h1234_5678);
    chk("rst.pre_curr", curr_pc_fd, 32'h80);
    phase_fetch = 1'b1;
    step();
    clear_inputs();
    chk("rst.pre_req", {31'b0, imem_req}, 32'h1);
    chk("rst.pre_addr", imem_addr, 32'h80);
    #3 rst_n = 1'b0;
    #1;
    chk_all("rst.async", 1'b0, 32'h0, NOP, 32'h0);
    step();
    rst_n = 1'b1;
    imem_ack = 1'b1; imem_rdata = 32'h0000_0BAD;
    step();
    step();
    clear_inputs();
    chk_all("rst.stale_ack", 1'b0, 32'h0, NOP, 32'h0);
    phase_fetch = 1'b1;
    step();
    clear_inputs();
    chk_all("rst.refetch", 1'b1, 32'h0, NOP, 32'h0);
    imem_ack = 1'b1; imem_rdata = 32'h0000_0093;
    step();
    clear_inputs();
    chk_all("rst.refetch_ack", 1'b0, 32'h0, 32'h0000_0093, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage directly upstream of instruction_decode. Holds the architectural PC and issues one instruction-memory read per fetch phase over a req/ack handshake. Presents the fetched word (inst) and its address (curr_pc_fd) to decode. Asserts stall_fetch while the memory has not yet answered, and updates the PC at writeback from the sequential or jump target.

Parameters:
XLEN, 32, datapath/PC width.
RESET_VECTOR, 32'h0000_0000, PC value after reset; must be 4-byte aligned.
NOP_INST, 32'h0000_0013, value of inst after reset (ADDI x0,x0,0).

Ports:
clk  in  1  CPU clock, all state on rising edge
rst_n  in  1  asynchronous reset, active-low
phase_fetch  in  1  one-cycle strobe: start fetch at current PC
phase_writeback  in  1  one-cycle strobe: commit PC update
jump_state  in  1  sampled with phase_writeback; 1 = take next_pc
next_pc  in  XLEN  jump/branch target from execute
imem_req  out  1  memory read request, registered
imem_addr  out  XLEN  read address, registered, stable while imem_req=1
imem_ack  in  1  read data valid this cycle; ignored when imem_req=0
imem_rdata  in  32  read data, sampled when imem_req & imem_ack
inst  out  32  fetched instruction, registered
curr_pc_fd  out  XLEN  address of inst, registered
stall_fetch  out  1  1 while a fetch is outstanding

Behaviour:
- Reset (async, any state): state=IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, inst=NOP_INST, curr_pc_fd=RESET_VECTOR, pend_valid=0, stall_fetch=0.
- States: IDLE, WAIT.
- IDLE & phase_fetch: next edge imem_req<=1, imem_addr<=pc, state<=WAIT.
- IDLE & no phase_fetch: outputs hold.
- WAIT: imem_req and imem_addr held unchanged until imem_ack.
- WAIT & imem_ack: inst<=imem_rdata, curr_pc_fd<=imem_addr, imem_req<=0, state<=IDLE.
- WAIT & phase_fetch: ignored. No queuing, no second request.
- Min latency: phase_fetch at T, imem_req=1 from T+1. Ack at T+1 gives inst/curr_pc_fd valid at T+2. Each ack wait cycle adds 1.
- stall_fetch = (state==WAIT), combinational from the state register.
- PC update target: jump_state ? {next_pc[XLEN-1:2],2'b00} : pc+4. The +4 wraps modulo 2^XLEN. Low two bits of next_pc are discarded; no misalignment trap.
- phase_writeback in IDLE: pc<=target on the next edge.
- phase_writeback in WAIT: target goes into a pend register and pend_valid<=1. pc<=pend on the ack edge (same edge inst is captured); pend_valid<=0. imem_addr of the outstanding request is not disturbed.
- phase_writeback and imem_ack on the same edge in WAIT: pc<=target directly, pend unused.
- phase_writeback and phase_fetch on the same edge in IDLE: the fetch uses the old pc; pc updates afterwards.
- A second phase_writeback while pend_valid=1 overwrites pend (last wins).
- inst and curr_pc_fd change only on an ack edge or on reset.

Test Plan:
- Reset release, then phase_fetch at T, imem_ack=1 at T+1 with rdata=32'h00500093 -> imem_addr=0 at T+1; inst=32'h00500093, curr_pc_fd=0, stall_fetch=0 at T+2.
- Same fetch with ack delayed 3 cycles -> stall_fetch=1 for exactly 3 cycles; imem_addr stable at 0; a phase_fetch pulse mid-wait causes no extra request.
- phase_writeback, jump_state=0, pc=32'hFFFF_FFFC -> next fetch address 32'h0000_0000 (wrap).
- phase_writeback, jump_state=1, next_pc=32'h0000_0107 -> next fetch address 32'h0000_0104.
- phase_writeback, jump_state=1, next_pc=32'h200 while WAIT, ack two cycles later -> outstanding imem_addr unchanged; next fetch address 32'h200.
- Assert rst_n=0 mid-WAIT with imem_req=1 -> imem_req=0, inst=32'h00000013, curr_pc_fd=0 immediately (asynchronously); a later stale imem_ack is ignored.
